// File: rtl/slc3_pkg.sv
// Shared SLC-3 definitions: control FSM states, opcodes, mux/ALU encodings, control word.
package slc3_pkg;

  localparam int unsigned OPC_W = 4;
  localparam int unsigned SEL_W = 2;

  typedef enum logic [4:0] {
    HALTED, S18, S33_1, S33_2, S33_3, S35, S32,
    S01, S05, S09, S00, S22, S12, S04, S21,
    S06, S25_1, S25_2, S25_3, S27,
    S07, S23, S16_1, S16_2, S16_3,
    PAUSE_1, PAUSE_2
  } state_t;

  localparam logic [OPC_W-1:0] OP_ADD = 4'b0001;
  localparam logic [OPC_W-1:0] OP_AND = 4'b0101;
  localparam logic [OPC_W-1:0] OP_NOT = 4'b1001;
  localparam logic [OPC_W-1:0] OP_BR  = 4'b0000;
  localparam logic [OPC_W-1:0] OP_JMP = 4'b1100;
  localparam logic [OPC_W-1:0] OP_JSR = 4'b0100;
  localparam logic [OPC_W-1:0] OP_LDR = 4'b0110;
  localparam logic [OPC_W-1:0] OP_STR = 4'b0111;
  localparam logic [OPC_W-1:0] OP_PSE = 4'b1101;

  localparam logic [SEL_W-1:0] PCMUX_INC   = 2'd0;
  localparam logic [SEL_W-1:0] PCMUX_BUS   = 2'd1;
  localparam logic [SEL_W-1:0] PCMUX_ADDER = 2'd2;

  localparam logic [SEL_W-1:0] ADDR2_ZERO  = 2'd0;
  localparam logic [SEL_W-1:0] ADDR2_OFF6  = 2'd1;
  localparam logic [SEL_W-1:0] ADDR2_OFF9  = 2'd2;
  localparam logic [SEL_W-1:0] ADDR2_OFF11 = 2'd3;

  localparam logic [SEL_W-1:0] ALUK_ADD  = 2'd0;
  localparam logic [SEL_W-1:0] ALUK_AND  = 2'd1;
  localparam logic [SEL_W-1:0] ALUK_NOT  = 2'd2;
  localparam logic [SEL_W-1:0] ALUK_PASS = 2'd3;

  localparam logic ADDR1_PC      = 1'b0;
  localparam logic ADDR1_SR1     = 1'b1;
  localparam logic DRMUX_IR11_9  = 1'b0;
  localparam logic DRMUX_R7      = 1'b1;
  localparam logic SR1MUX_IR8_6  = 1'b0;
  localparam logic SR1MUX_IR11_9 = 1'b1;
  localparam logic SR2MUX_REG    = 1'b0;
  localparam logic SR2MUX_IMM    = 1'b1;

  // Full control word driven by the ISDU toward the datapath and SRAM
  typedef struct packed {
    logic             ld_mar;
    logic             ld_mdr;
    logic             ld_ir;
    logic             ld_ben;
    logic             ld_cc;
    logic             ld_reg;
    logic             ld_pc;
    logic             ld_led;
    logic             gatepc;
    logic             gatemdr;
    logic             gatealu;
    logic             gatemarmux;
    logic [SEL_W-1:0] pcmux;
    logic [SEL_W-1:0] addr2mux;
    logic [SEL_W-1:0] aluk;
    logic             drmux;
    logic             sr1mux;
    logic             sr2mux;
    logic             addr1mux;
    logic             mem_ce;
    logic             mem_ub;
    logic             mem_lb;
    logic             mem_oe;
    logic             mem_we;
  } ctrl_t;

  // Idle control word; the SRAM stays selected everywhere except HALTED
  function automatic ctrl_t ctrl_idle(input logic halted);
    ctrl_t c;
    c        = '0;
    c.mem_ce = halted;
    c.mem_ub = halted;
    c.mem_lb = halted;
    c.mem_oe = 1'b1;
    c.mem_we = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/isdu.sv
// SLC-3 instruction sequencer/decoder: fetch, decode, execute and pause control FSM.
module isdu
  import slc3_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             cont,
  input  logic [OPC_W-1:0] opcode,
  input  logic             ir_5,
  input  logic             ben,
  output logic             ld_mar,
  output logic             ld_mdr,
  output logic             ld_ir,
  output logic             ld_ben,
  output logic             ld_cc,
  output logic             ld_reg,
  output logic             ld_pc,
  output logic             ld_led,
  output logic             gatepc,
  output logic             gatemdr,
  output logic             gatealu,
  output logic             gatemarmux,
  output logic [SEL_W-1:0] pcmux,
  output logic [SEL_W-1:0] addr2mux,
  output logic [SEL_W-1:0] aluk,
  output logic             drmux,
  output logic             sr1mux,
  output logic             sr2mux,
  output logic             addr1mux,
  output logic             mem_ce,
  output logic             mem_ub,
  output logic             mem_lb,
  output logic             mem_oe,
  output logic             mem_we,
  output state_t           state
);

  state_t state_q, state_d;
  ctrl_t  ctrl_q, ctrl_d;

  // State and control-word registers; reset aborts any SRAM cycle at once
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= HALTED;
      ctrl_q  <= ctrl_idle(1'b1);
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
    end
  end

  // Next-state sequencing
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      HALTED:  if (!run) state_d = S18;
      S18:     state_d = S33_1;
      S33_1:   state_d = S33_2;
      S33_2:   state_d = S33_3;
      S33_3:   state_d = S35;
      S35:     state_d = S32;
      S32: begin
        case (opcode)
          OP_ADD:  state_d = S01;
          OP_AND:  state_d = S05;
          OP_NOT:  state_d = S09;
          OP_BR:   state_d = S00;
          OP_JMP:  state_d = S12;
          OP_JSR:  state_d = S04;
          OP_LDR:  state_d = S06;
          OP_STR:  state_d = S07;
          OP_PSE:  state_d = PAUSE_1;
          default: state_d = S18;
        endcase
      end
      S01, S05, S09, S22, S12, S21, S27, S16_3: state_d = S18;
      S00:     state_d = ben ? S22 : S18;
      S04:     state_d = S21;
      S06:     state_d = S25_1;
      S25_1:   state_d = S25_2;
      S25_2:   state_d = S25_3;
      S25_3:   state_d = S27;
      S07:     state_d = S23;
      S23:     state_d = S16_1;
      S16_1:   state_d = S16_2;
      S16_2:   state_d = S16_3;
      PAUSE_1: if (!cont) state_d = PAUSE_2;
      PAUSE_2: if (cont) state_d = S18;
      default: state_d = HALTED;
    endcase
  end

  // Control word for the state being entered, so outputs line up with state_q
  always_comb begin
    ctrl_d = ctrl_idle(state_d == HALTED);
    case (state_d)
      S18: begin
        ctrl_d.gatepc = 1'b1;
        ctrl_d.ld_mar = 1'b1;
        ctrl_d.pcmux  = PCMUX_INC;
        ctrl_d.ld_pc  = 1'b1;
      end
      S33_1, S33_2, S25_1, S25_2: ctrl_d.mem_oe = 1'b0;
      S33_3, S25_3: begin
        ctrl_d.mem_oe = 1'b0;
        ctrl_d.ld_mdr = 1'b1;
      end
      S35: begin
        ctrl_d.gatemdr = 1'b1;
        ctrl_d.ld_ir   = 1'b1;
      end
      S32: ctrl_d.ld_ben = 1'b1;
      S01, S05, S09: begin
        ctrl_d.gatealu = 1'b1;
        ctrl_d.ld_reg  = 1'b1;
        ctrl_d.ld_cc   = 1'b1;
        ctrl_d.sr2mux  = ir_5;
        ctrl_d.aluk    = (state_d == S01) ? ALUK_ADD :
                         (state_d == S05) ? ALUK_AND : ALUK_NOT;
      end
      S22, S21: begin
        ctrl_d.addr1mux = ADDR1_PC;
        ctrl_d.addr2mux = (state_d == S22) ? ADDR2_OFF9 : ADDR2_OFF11;
        ctrl_d.pcmux    = PCMUX_ADDER;
        ctrl_d.ld_pc    = 1'b1;
      end
      S12: begin
        ctrl_d.addr1mux = ADDR1_SR1;
        ctrl_d.addr2mux = ADDR2_ZERO;
        ctrl_d.pcmux    = PCMUX_ADDER;
        ctrl_d.ld_pc    = 1'b1;
      end
      S04: begin
        ctrl_d.gatepc = 1'b1;
        ctrl_d.drmux  = DRMUX_R7;
        ctrl_d.ld_reg = 1'b1;
      end
      S06, S07: begin
        ctrl_d.addr1mux   = ADDR1_SR1;
        ctrl_d.addr2mux   = ADDR2_OFF6;
        ctrl_d.gatemarmux = 1'b1;
        ctrl_d.ld_mar     = 1'b1;
      end
      S27: begin
        ctrl_d.gatemdr = 1'b1;
        ctrl_d.ld_reg  = 1'b1;
        ctrl_d.ld_cc   = 1'b1;
      end
      S23: begin
        ctrl_d.sr1mux  = SR1MUX_IR11_9;
        ctrl_d.aluk    = ALUK_PASS;
        ctrl_d.gatealu = 1'b1;
        ctrl_d.ld_mdr  = 1'b1;
      end
      S16_1, S16_2, S16_3: ctrl_d.mem_we = 1'b0;
      PAUSE_1: ctrl_d.ld_led = (state_q != PAUSE_1);
      default: ;
    endcase
  end

  assign state      = state_q;
  assign ld_mar     = ctrl_q.ld_mar;
  assign ld_mdr     = ctrl_q.ld_mdr;
  assign ld_ir      = ctrl_q.ld_ir;
  assign ld_ben     = ctrl_q.ld_ben;
  assign ld_cc      = ctrl_q.ld_cc;
  assign ld_reg     = ctrl_q.ld_reg;
  assign ld_pc      = ctrl_q.ld_pc;
  assign ld_led     = ctrl_q.ld_led;
  assign gatepc     = ctrl_q.gatepc;
  assign gatemdr    = ctrl_q.gatemdr;
  assign gatealu    = ctrl_q.gatealu;
  assign gatemarmux = ctrl_q.gatemarmux;
  assign pcmux      = ctrl_q.pcmux;
  assign addr2mux   = ctrl_q.addr2mux;
  assign aluk       = ctrl_q.aluk;
  assign drmux      = ctrl_q.drmux;
  assign sr1mux     = ctrl_q.sr1mux;
  assign sr2mux     = ctrl_q.sr2mux;
  assign addr1mux   = ctrl_q.addr1mux;
  assign mem_ce     = ctrl_q.mem_ce;
  assign mem_ub     = ctrl_q.mem_ub;
  assign mem_lb     = ctrl_q.mem_lb;
  assign mem_oe     = ctrl_q.mem_oe;
  assign mem_we     = ctrl_q.mem_we;

endmodule

// File: tb/tb_isdu.sv
// Directed, table-driven bench for the SLC-3 ISDU.
module tb_isdu;
  import slc3_pkg::*;

  logic clk = 1'b0;
  logic reset, run, cont, ir_5, ben;
  logic [3:0] opcode;
  logic ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc, ld_led;
  logic gatepc, gatemdr, gatealu, gatemarmux;
  logic [1:0] pcmux, addr2mux, aluk;
  logic drmux, sr1mux, sr2mux, addr1mux;
  logic mem_ce, mem_ub, mem_lb, mem_oe, mem_we;
  state_t st;

  int checks = 0;
  int failures = 0;
  state_t prev_s;
  ctrl_t act;

  isdu dut (
    .clk(clk), .reset(reset), .run(run), .cont(cont), .opcode(opcode),
    .ir_5(ir_5), .ben(ben),
    .ld_mar(ld_mar), .ld_mdr(ld_mdr), .ld_ir(ld_ir), .ld_ben(ld_ben),
    .ld_cc(ld_cc), .ld_reg(ld_reg), .ld_pc(ld_pc), .ld_led(ld_led),
    .gatepc(gatepc), .gatemdr(gatemdr), .gatealu(gatealu), .gatemarmux(gatemarmux),
    .pcmux(pcmux), .addr2mux(addr2mux), .aluk(aluk), .drmux(drmux),
    .sr1mux(sr1mux), .sr2mux(sr2mux), .addr1mux(addr1mux),
    .mem_ce(mem_ce), .mem_ub(mem_ub), .mem_lb(mem_lb), .mem_oe(mem_oe),
    .mem_we(mem_we), .state(st)
  );

  always #5 clk = ~clk;

  // Gather DUT outputs into one word for comparison
  always_comb begin
    act            = '0;
    act.ld_mar     = ld_mar;
    act.ld_mdr     = ld_mdr;
    act.ld_ir      = ld_ir;
    act.ld_ben     = ld_ben;
    act.ld_cc      = ld_cc;
    act.ld_reg     = ld_reg;
    act.ld_pc      = ld_pc;
    act.ld_led     = ld_led;
    act.gatepc     = gatepc;
    act.gatemdr    = gatemdr;
    act.gatealu    = gatealu;
    act.gatemarmux = gatemarmux;
    act.pcmux      = pcmux;
    act.addr2mux   = addr2mux;
    act.aluk       = aluk;
    act.drmux      = drmux;
    act.sr1mux     = sr1mux;
    act.sr2mux     = sr2mux;
    act.addr1mux   = addr1mux;
    act.mem_ce     = mem_ce;
    act.mem_ub     = mem_ub;
    act.mem_lb     = mem_lb;
    act.mem_oe     = mem_oe;
    act.mem_we     = mem_we;
  end

  // Expected control word for state s, entered from state p
  function automatic ctrl_t exp_ctrl(input state_t s, input state_t p, input logic i5);
    ctrl_t c;
    c = '0;
    c.mem_oe = 1'b1;
    c.mem_we = 1'b1;
    if (s == HALTED) begin
      c.mem_ce = 1'b1; c.mem_ub = 1'b1; c.mem_lb = 1'b1;
    end
    case (s)
      S18:   begin c.gatepc = 1; c.ld_mar = 1; c.ld_pc = 1; c.pcmux = PCMUX_INC; end
      S33_1: c.mem_oe = 0;
      S33_2: c.mem_oe = 0;
      S33_3: begin c.mem_oe = 0; c.ld_mdr = 1; end
      S25_1: c.mem_oe = 0;
      S25_2: c.mem_oe = 0;
      S25_3: begin c.mem_oe = 0; c.ld_mdr = 1; end
      S35:   begin c.gatemdr = 1; c.ld_ir = 1; end
      S32:   c.ld_ben = 1;
      S01:   begin c.gatealu = 1; c.ld_reg = 1; c.ld_cc = 1; c.aluk = ALUK_ADD; c.sr2mux = i5; end
      S05:   begin c.gatealu = 1; c.ld_reg = 1; c.ld_cc = 1; c.aluk = ALUK_AND; c.sr2mux = i5; end
      S09:   begin c.gatealu = 1; c.ld_reg = 1; c.ld_cc = 1; c.aluk = ALUK_NOT; c.sr2mux = i5; end
      S22:   begin c.addr1mux = ADDR1_PC; c.addr2mux = ADDR2_OFF9; c.pcmux = PCMUX_ADDER; c.ld_pc = 1; end
      S12:   begin c.addr1mux = ADDR1_SR1; c.addr2mux = ADDR2_ZERO; c.pcmux = PCMUX_ADDER; c.ld_pc = 1; end
      S04:   begin c.gatepc = 1; c.drmux = DRMUX_R7; c.ld_reg = 1; end
      S21:   begin c.addr1mux = ADDR1_PC; c.addr2mux = ADDR2_OFF11; c.pcmux = PCMUX_ADDER; c.ld_pc = 1; end
      S06:   begin c.addr1mux = ADDR1_SR1; c.addr2mux = ADDR2_OFF6; c.gatemarmux = 1; c.ld_mar = 1; end
      S07:   begin c.addr1mux = ADDR1_SR1; c.addr2mux = ADDR2_OFF6; c.gatemarmux = 1; c.ld_mar = 1; end
      S27:   begin c.gatemdr = 1; c.ld_reg = 1; c.ld_cc = 1; end
      S23:   begin c.sr1mux = SR1MUX_IR11_9; c.aluk = ALUK_PASS; c.gatealu = 1; c.ld_mdr = 1; end
      S16_1: c.mem_we = 0;
      S16_2: c.mem_we = 0;
      S16_3: c.mem_we = 0;
      PAUSE_1: c.ld_led = (p != PAUSE_1);
      default: ;
    endcase
    return c;
  endfunction

  task automatic chk(input string name, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, a, e);
    end
  endtask

  // Advance one edge and sample 1 time unit later; OE/WE must never overlap
  task automatic tick();
    @(posedge clk);
    #1;
    chk("oe_we_exclusive", 32'({mem_oe, mem_we} == 2'b00), 32'd0);
  endtask

  task automatic step(input state_t exp_s, input string tag);
    tick();
    chk({tag, " state"}, 32'(st), 32'(exp_s));
    chk({tag, " ctrl"}, 32'(act), 32'(exp_ctrl(exp_s, prev_s, ir_5)));
    prev_s = exp_s;
  endtask

  task automatic fetch(input string tag);
    step(S33_1, tag); step(S33_2, tag); step(S33_3, tag);
    step(S35, tag);   step(S32, tag);
  endtask

  typedef struct {
    string        name;
    logic [3:0]   opc;
    logic         b;
    logic         i5;
    int           len;
    state_t       path [5];
  } vec_t;

  vec_t vecs [11];

  task automatic set_vec(input int k, input string n, input logic [3:0] o, input logic b,
                         input logic i5, input int l, input state_t p0, input state_t p1,
                         input state_t p2, input state_t p3, input state_t p4);
    vecs[k].name = n; vecs[k].opc = o; vecs[k].b = b; vecs[k].i5 = i5; vecs[k].len = l;
    vecs[k].path[0] = p0; vecs[k].path[1] = p1; vecs[k].path[2] = p2;
    vecs[k].path[3] = p3; vecs[k].path[4] = p4;
  endtask

  int we_low;

  initial begin
    set_vec(0,  "add",    4'b0001, 1'b0, 1'b1, 1, S01, S18, S18, S18, S18);
    set_vec(1,  "and",    4'b0101, 1'b0, 1'b0, 1, S05, S18, S18, S18, S18);
    set_vec(2,  "not",    4'b1001, 1'b0, 1'b1, 1, S09, S18, S18, S18, S18);
    set_vec(3,  "br_nt",  4'b0000, 1'b0, 1'b0, 1, S00, S18, S18, S18, S18);
    set_vec(4,  "br_tk",  4'b0000, 1'b1, 1'b0, 2, S00, S22, S18, S18, S18);
    set_vec(5,  "jmp",    4'b1100, 1'b0, 1'b0, 1, S12, S18, S18, S18, S18);
    set_vec(6,  "jsr",    4'b0100, 1'b0, 1'b0, 2, S04, S21, S18, S18, S18);
    set_vec(7,  "ldr",    4'b0110, 1'b0, 1'b0, 5, S06, S25_1, S25_2, S25_3, S27);
    set_vec(8,  "str",    4'b0111, 1'b0, 1'b0, 5, S07, S23, S16_1, S16_2, S16_3);
    set_vec(9,  "nop_f",  4'b1111, 1'b0, 1'b0, 0, S18, S18, S18, S18, S18);
    set_vec(10, "nop_a",  4'b1010, 1'b1, 1'b1, 0, S18, S18, S18, S18, S18);

    reset = 1'b0; run = 1'b1; cont = 1'b1; opcode = 4'b0001; ir_5 = 1'b0; ben = 1'b0;
    #12;
    prev_s = HALTED;
    chk("reset state", 32'(st), 32'(HALTED));
    chk("reset ctrl", 32'(act), 32'(exp_ctrl(HALTED, HALTED, 1'b0)));

    // Reset released, Run idle: HALTED must hold
    reset = 1'b1;
    step(HALTED, "idle0");
    step(HALTED, "idle1");
    step(HALTED, "idle2");

    // Start; Run stays pressed for the whole table
    run = 1'b0;
    step(S18, "start");

    for (int k = 0; k < 11; k++) begin
      opcode = vecs[k].opc; ben = vecs[k].b; ir_5 = vecs[k].i5;
      fetch(vecs[k].name);
      for (int j = 0; j < vecs[k].len; j++) step(vecs[k].path[j], vecs[k].name);
      step(S18, vecs[k].name);
    end

    // STR: WE low for exactly three consecutive cycles
    opcode = 4'b0111; ben = 1'b0; ir_5 = 1'b0;
    we_low = 0;
    fetch("str_cnt");
    for (int j = 0; j < 6; j++) begin
      tick();
      if (!mem_we) we_low++;
      if (st == S18) break;
    end
    chk("str we_low cycles", 32'(we_low), 32'd3);
    chk("str back to S18", 32'(st), 32'(S18));
    prev_s = S18;

    // Pause: LED load on entry only, hold, press then release
    opcode = 4'b1101;
    fetch("pause");
    step(PAUSE_1, "pause_entry");
    for (int j = 0; j < 10; j++) step(PAUSE_1, "pause_hold");
    cont = 1'b0;
    step(PAUSE_2, "pause_press");
    step(PAUSE_2, "pause_held");
    cont = 1'b1;
    step(S18, "pause_release");

    // Reset in the middle of a store aborts the write at once
    opcode = 4'b0111;
    fetch("str_rst");
    step(S07, "str_rst");
    step(S23, "str_rst");
    step(S16_1, "str_rst");
    step(S16_2, "str_rst");
    #3;
    run = 1'b1;
    reset = 1'b0;
    #1;
    chk("async reset mem_we", 32'(mem_we), 32'd1);
    chk("async reset state", 32'(st), 32'(HALTED));
    chk("async reset ctrl", 32'(act), 32'(exp_ctrl(HALTED, HALTED, 1'b0)));
    #2;
    reset = 1'b1;
    prev_s = HALTED;
    step(HALTED, "post_reset");
    run = 1'b0;
    step(S18, "restart");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time limit so the run always ends
  initial begin
    #100000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
